// File: rtl/wbrrarbiter.sv
// wbrrarbiter: four-master pipelined Wishbone arbiter.
// Grants one master at a time in round-robin order and holds the grant until
// that master drops its cycle line. Accepted strobes are counted as outstanding
// requests. A watchdog aborts a slave that stops answering and returns an error
// to the owning master.
module wbrrarbiter #(
  parameter int DW      = 32,
  parameter int AW      = 19,
  parameter int LGOUT   = 4,
  parameter int LGTO    = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [3:0]      i_cyc,
  input  logic [3:0]      i_stb,
  input  logic [3:0]      i_we,
  input  logic [4*AW-1:0] i_adr,
  input  logic [4*DW-1:0] i_dat,
  output logic [3:0]      o_ack,
  output logic [3:0]      o_stall,
  output logic [3:0]      o_err,
  output logic            o_cyc,
  output logic            o_stb,
  output logic            o_we,
  output logic [AW-1:0]   o_adr,
  output logic [DW-1:0]   o_dat,
  input  logic            i_ack,
  input  logic            i_stall,
  input  logic            i_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } state_t;

  // Last value the watchdog reaches before it fires on the next increment.
  localparam logic [LGTO-1:0] TO_LAST = LGTO'(TIMEOUT - 1);

  state_t           state;
  logic [1:0]       r_owner;
  logic [1:0]       r_last;
  logic [LGOUT-1:0] r_nout;
  logic [LGTO-1:0]  r_tocnt;

  logic             owner_cyc;
  logic             sat;
  logic             accept;
  logic             dec;
  logic [1:0]       sel;
  logic [LGOUT-1:0] nout_next;

  // Round-robin search: first requester after 'last', wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [1:0] last,
                                         input logic [3:0] req);
    logic [1:0] pick;
    logic [1:0] cand;
    logic       found;
    pick  = last + 2'd1;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last + i[1:0];
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  assign owner_cyc = i_cyc[r_owner];
  assign sat       = &r_nout;
  assign sel       = rr_pick(r_last, i_cyc);
  assign accept    = o_stb & ~i_stall;
  // An ack with nothing outstanding must not wrap the counter.
  assign dec       = i_ack & (r_nout != '0);

  // Address/data/write-enable always follow the current (or last) owner.
  always_comb begin
    o_we  = i_we[r_owner];
    o_adr = i_adr[int'(r_owner)*AW +: AW];
    o_dat = i_dat[int'(r_owner)*DW +: DW];
  end

  // Bus control and per-master response gating from state and live inputs.
  always_comb begin
    o_cyc   = 1'b0;
    o_stb   = 1'b0;
    o_ack   = 4'b0000;
    o_err   = 4'b0000;
    o_stall = 4'b1111;
    case (state)
      GRANT: begin
        o_cyc            = owner_cyc;
        o_stb            = owner_cyc & i_stb[r_owner] & ~sat;
        o_ack[r_owner]   = i_ack;
        o_err[r_owner]   = i_err;
        o_stall[r_owner] = i_stall | sat;
      end
      ABORT: begin
        o_err[r_owner] = 1'b1;
      end
      IDLE: begin
        o_cyc = 1'b0;
      end
      default: begin
        o_cyc = 1'b0;
      end
    endcase
  end

  // Outstanding-count next value: strobe in, ack out, both cancel.
  always_comb begin
    nout_next = r_nout;
    if (accept && !dec) begin
      nout_next = r_nout + LGOUT'(1);
    end else if (!accept && dec) begin
      nout_next = r_nout - LGOUT'(1);
    end else begin
      nout_next = r_nout;
    end
  end

  // Arbitration FSM with outstanding counter and watchdog.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      r_owner <= 2'd0;
      r_last  <= 2'd3;
      r_nout  <= '0;
      r_tocnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          r_nout  <= '0;
          r_tocnt <= '0;
          if (|i_cyc) begin
            r_owner <= sel;
            r_last  <= sel;
            state   <= GRANT;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (!owner_cyc) begin
            // Owner released: anything still outstanding is discarded.
            state   <= IDLE;
            r_nout  <= '0;
            r_tocnt <= '0;
          end else if (i_err) begin
            // Slave error ends the in-flight requests but keeps the grant.
            r_nout  <= '0;
            r_tocnt <= '0;
          end else if (i_ack || (r_nout == '0)) begin
            r_nout  <= nout_next;
            r_tocnt <= '0;
          end else if (r_tocnt == TO_LAST) begin
            state   <= ABORT;
            r_nout  <= '0;
            r_tocnt <= '0;
          end else begin
            r_nout  <= nout_next;
            r_tocnt <= r_tocnt + LGTO'(1);
          end
        end
        ABORT: begin
          state   <= IDLE;
          r_nout  <= '0;
          r_tocnt <= '0;
        end
        default: begin
          state   <= IDLE;
          r_nout  <= '0;
          r_tocnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/wbrrarbiter.md
# wbrrarbiter

Four-master Wishbone (pipelined) bus arbiter with round-robin fairness, outstanding-transaction tracking and a bus-timeout watchdog. It sits between up to four bus masters (CPU fetch, CPU load/store, debug bus, DMA) and a single downstream interconnect. It grants one master at a time and holds the grant until that master drops its cycle line. It guarantees at least one idle cycle between owners and aborts a hung slave with an error.

## Interface
- DW, 32, data width
- AW, 19, address width
- LGOUT, 4, outstanding-request counter width; maximum outstanding is 2^LGOUT-1
- LGTO, 10, timeout counter width
- TIMEOUT, 1000, cycles with outstanding>0 and no ack/err before abort; must be < 2^LGTO

- i_clk  in  1  clock; all state updates on its rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_cyc  in  4  per-master cycle request; bit k = master k
- i_stb  in  4  per-master strobe
- i_we  in  4  per-master write enable
- i_adr  in  4*AW  master k address at bits [k*AW +: AW]
- i_dat  in  4*DW  master k write data at bits [k*DW +: DW]
- o_ack  out  4  per-master ack
- o_stall  out  4  per-master stall
- o_err  out  4  per-master error
- o_cyc, o_stb, o_we  out  1 each  downstream bus controls
- o_adr  out  AW  downstream address
- o_dat  out  DW  downstream write data
- i_ack, i_stall, i_err  in  1 each  downstream responses

## Operation
- State machine: IDLE, GRANT, ABORT. Registers: r_owner (2b), r_last (2b), r_nout (LGOUT b), r_tocnt (LGTO b).
- IDLE: if any i_cyc bit is set, select the first requester searching r_last+1, r_last+2, … modulo 4. Set r_owner=r_last=sel and go to GRANT. Otherwise stay in IDLE.
- GRANT, owner's i_cyc=1: o_cyc=1. o_stb=i_stb[r_owner], except forced 0 when r_nout is all ones. o_adr/o_dat/o_we are muxed from r_owner in every state.
- GRANT, owner's i_cyc=0: o_cyc=o_stb=0 in that same cycle, then go to IDLE. r_nout and r_tocnt clear, discarding any outstanding requests.
- Bus gating:
  - o_ack[k]=i_ack and o_err[k]=i_err only in GRANT with k==r_owner.
  - o_stall[k]=i_stall (or 1 when r_nout is saturated) only for the owner in GRANT. Every non-owner sees o_stall=1.
- r_nout update: +1 on an accepted strobe (o_stb && !i_stall), −1 on i_ack. Both together leave it unchanged.
- On i_err in GRANT: error passed to owner, r_nout cleared, grant retained until the owner drops i_cyc.
- Watchdog:
  - r_tocnt increments each GRANT cycle with r_nout>0 and neither i_ack nor i_err.
  - Clears on any ack or err, and whenever r_nout==0.
  - When r_tocnt reaches TIMEOUT-1 and increments, go to ABORT.
- ABORT: lasts one cycle. o_cyc=o_stb=0, o_err[r_owner]=1, o_ack=0, all stalls 1. r_nout and r_tocnt clear. Next state IDLE.
- Ack/err arriving while not in GRANT are dropped.

## Timing
- Reset (async) values:
  - State: IDLE. r_owner=0, r_last=3 (master 0 wins the first arbitration), counters 0.
  - Outputs: o_cyc=o_stb=0, o_ack=o_err=0, o_stall=4'b1111. o_adr/o_dat/o_we follow master 0.
- Grant latency: i_cyc[k] rises in cycle n while in IDLE → o_cyc=1 in cycle n+1. The master is stalled in cycle n.
- Release: owner drops i_cyc in cycle m → o_cyc=0 in cycle m. IDLE holds in m+1, so the earliest next grant is o_cyc=1 at m+2. There is always at least one o_cyc=0 cycle between owners.
- Simultaneous requests are resolved by round robin only. A master that holds i_cyc can never be starved for more than three other tenures.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronously). No ack or err is delivered.

## Test plan
- Single master: after reset, i_cyc=4'b0100 with 3 strobes, slave acks each 1 cycle later → o_cyc rises 1 cycle after request; o_ack[2] pulses 3 times; o_stall[0,1,3]=1 throughout.
- Round robin: i_cyc=4'b1111 held; each owner does 1 transfer, then drops i_cyc for 1 cycle and re-raises → grant order 0,1,2,3,0; one idle o_cyc cycle between each tenure.
- Saturation, LGOUT=2: owner strobes continuously, slave never acks → after 3 accepted strobes o_stb=0 and o_stall[owner]=1; then 1 ack → exactly one more strobe accepted.
- Timeout, TIMEOUT=16: 1 strobe accepted, no ack → 16 cycles later o_err[owner]=1 for 1 cycle with o_cyc=0; the next request is granted 1 cycle after that.
- Slave error: i_err during master 1's transfer → o_err[1]=1 in the same cycle, o_err of all other masters 0, grant retained until i_cyc[1] drops.
- Async reset asserted mid-GRANT with 2 outstanding → o_cyc=0, o_stall=4'b1111 before the next clock edge; after release, master 0 wins if all four request.
